uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares the single UART transmit path between `NUM_REQ` on-chip message sources; sits directly in front of the `uart` block's TX FIFO write port.
- Grants whole messages round-robin, so bytes from different sources never interleave.
- Paces writes with a credit counter. The UART exposes no TX-FIFO-full flag, so the arbiter tracks FIFO occupancy itself by modelling the drain rate.
- Releases a stalled requester after a timeout so one source cannot hold the link.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `FIFO_DEPTH`, 64: depth of the downstream UART TX FIFO; initial credit count.
- `CLOCK_FREQUENCY`, 27000000: system clock in Hz.
- `BAUD_RATE`, 115200: UART baud rate.
- `IDLE_TIMEOUT`, 1024: cycles of `req_valid` low mid-message before forced release.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_data` input 8*NUM_REQ: byte from requester i on bits [8i+7:8i].
- `req_valid` input NUM_REQ: requester i has a byte.
- `req_last` input NUM_REQ: the current byte is the final byte of the message.
- `req_ready` output NUM_REQ: requester i's byte is accepted this cycle when valid is also high.
- `tx_fifo_data_in` output 8: byte to the UART TX FIFO.
- `tx_fifo_write_en` output 1: one-cycle write strobe to the UART TX FIFO.
- `grant_id` output $clog2(NUM_REQ): index of the current or most recent owner.
- `busy` output 1: a message is in progress (state XFER).
- `timeout_pulse` output 1: one-cycle pulse on forced release.

## Operation
- Constant `BYTE_CYCLES = (CLOCK_FREQUENCY/BAUD_RATE)*10 + 2`. This gives 2342 at the default parameters. The +2 absorbs per-byte UART load overhead, so the credit estimate is always conservative.
- State IDLE:
  - If any `req_valid` is high, pick the winner round-robin, searching upward from `rr_ptr` and wrapping.
  - Register `grant_id` and go to XFER.
- State XFER:
  - `req_ready[grant_id] = (credits != 0)`; all other ready bits are 0.
  - Accepted byte (valid & ready): the byte is registered onto `tx_fifo_data_in`, and `tx_fifo_write_en` pulses for 1 cycle on the next clock. Credits decrement by 1.
  - Accepted byte with `req_last`: go to IDLE and set `rr_ptr = grant_id + 1` (mod NUM_REQ).
  - Granted `req_valid` low: the idle counter increments. It resets to 0 on any accepted byte.
  - Idle counter reaches IDLE_TIMEOUT-1: go to IDLE, pulse `timeout_pulse`, set `rr_ptr = grant_id + 1`.
  - Credit stall (`credits == 0`) does not advance the idle counter.
- Credit return:
  - The byte timer runs only while `credits < FIFO_DEPTH`.
  - Each time it reaches BYTE_CYCLES-1, credits increment by 1 and the timer restarts at 0.
  - When credits reach FIFO_DEPTH, the timer holds at 0.
- Simultaneous write and credit return: credits are unchanged.
- Credits never exceed FIFO_DEPTH and never go below 0. Width is $clog2(FIFO_DEPTH+1).
- Requests from non-granted requesters are ignored until the next IDLE.

## Timing
- Reset values:
  - All `req_ready` = 0; `tx_fifo_write_en` = 0; `tx_fifo_data_in` = 0.
  - `grant_id` = 0; `busy` = 0; `timeout_pulse` = 0.
  - state = IDLE; `rr_ptr` = 0; credits = FIFO_DEPTH; byte timer = 0; idle counter = 0.
- Grant latency: `req_valid` high in IDLE at cycle N gives `busy`/`req_ready` high at N+1.
- Byte latency: accept at cycle N gives `tx_fifo_write_en` at N+1.
- Throughput: 1 byte/cycle while credits last.
- Messages are separated by at least one IDLE cycle.
- Reset asserted mid-message:
  - Everything returns to reset values on the next edge.
  - Any partially sent message is abandoned; there is no flush.
- A single-byte message (valid & last together) is legal: XFER lasts 1 cycle.

## Structure
- Package `uart_arb_pkg` holds:
  - The state enum {IDLE, XFER}.
  - The `BYTE_CYCLES` computation function.
  - The credit-width helper.
- Sub-module `rr_picker`: combinational round-robin selector. Inputs are the request vector and `rr_ptr`; outputs are the winner index and an any-request flag. Test it separately.
- The top level holds the FSM, credit counter, byte timer, idle counter and output registers.

## Test plan
- Single requester, 3-byte message 0x41, 0x42, 0x43 (last on 0x43):
  - Three `tx_fifo_write_en` pulses on consecutive cycles carrying 0x41, 0x42, 0x43.
  - Credits go 64→61; `busy` falls after the last byte.
- Requesters 0 and 2 both valid from reset: requester 0 is granted first; requester 2 is granted after req0's last byte plus 1 IDLE cycle. No interleaved bytes.
- All 4 requesters continuously valid with 1-byte messages: grants cycle 0,1,2,3,0 with `rr_ptr` wrapping.
- Burst of 70 bytes from one requester:
  - After 64 accepts, `req_ready` drops.
  - It rises again for exactly one byte every 2342 cycles.
  - Credits never exceed 64.
- Granted requester drops valid mid-message for 1024 cycles: `timeout_pulse` fires once, state returns to IDLE, and the next pending requester is granted.
- Reset asserted mid-message: all outputs return to reset values on the next edge, and credits return to 64.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and helper functions for the UART TX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter FSM states: waiting for a requester, or moving one message
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Clock cycles the UART needs to shift out one 10-bit frame, plus a small
    // margin for its per-byte load overhead so the credit model never runs
    // ahead of the real FIFO drain.
    function automatic int byte_cycles(input int clk_hz, input int baud);
        return (clk_hz / baud) * 10 + 2;
    endfunction

    // Bits needed to hold a credit count from 0 up to and including depth
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Searches the request
//                vector upward from ptr (wrapping) and returns the first hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int IDW = $clog2(NUM_REQ);

    // Two copies side by side so a single right shift rotates ptr to bit 0
    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;

    assign doubled = {req, req};
    assign rotated = doubled >> ptr;

    // Lowest rotated offset wins; scan downward so the last hit is the closest
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                winner  = IDW'((int'(ptr) + k) % NUM_REQ);
                any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Message-level round-robin arbiter in front of the UART TX
//                FIFO, with credit-based pacing derived from the baud rate
//                and an idle timeout that releases a stalled owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int FIFO_DEPTH      = 64,
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int IDLE_TIMEOUT    = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_fifo_data_in,
    output logic                       tx_fifo_write_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_pulse
);

    localparam int IDW         = $clog2(NUM_REQ);
    localparam int BYTE_CYCLES = byte_cycles(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CW          = credit_width(FIFO_DEPTH);
    localparam int TW          = $clog2(BYTE_CYCLES + 1);
    localparam int ITW         = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [IDW-1:0] LAST_ID     = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  CREDIT_FULL = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0]  TIMER_MAX   = TW'(BYTE_CYCLES - 1);
    localparam logic [ITW-1:0] IDLE_MAX    = ITW'(IDLE_TIMEOUT - 1);

    arb_state_t     state;
    arb_state_t     next_state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  credits;
    logic [TW-1:0]  byte_timer;
    logic [ITW-1:0] idle_cnt;

    logic [IDW-1:0] winner;
    logic           any_req;
    logic           sel_valid;
    logic           sel_last;
    logic [7:0]     sel_byte;
    logic           have_credit;
    logic           accept;
    logic           idle_step;
    logic           timeout_hit;
    logic           release_grant;
    logic           credit_return;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign busy          = (state == XFER);
    assign have_credit   = (credits != '0);
    assign accept        = busy && have_credit && sel_valid;
    // A credit stall is not the requester's fault, so only count idle
    // cycles while the link could actually have taken a byte.
    assign idle_step     = busy && have_credit && !sel_valid;
    assign timeout_hit   = idle_step && (idle_cnt == IDLE_MAX);
    assign release_grant = (accept && sel_last) || timeout_hit;
    assign credit_return = (credits != CREDIT_FULL) && (byte_timer == TIMER_MAX);

    // Route the current owner's request signals and drive its ready bit only
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_byte     = req_data[8*i +: 8];
                req_ready[i] = busy && have_credit;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: grant on any request, release on last byte or timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = XFER;
            XFER:    if (release_grant) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Owner, round-robin pointer and idle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id <= winner;
            end
            if (busy && release_grant) begin
                rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
            if (!busy || accept || release_grant) begin
                idle_cnt <= '0;
            end else if (idle_step) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Registered FIFO write port and timeout strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_fifo_write_en <= 1'b0;
            tx_fifo_data_in  <= '0;
            timeout_pulse    <= 1'b0;
        end else begin
            tx_fifo_write_en <= accept;
            if (accept) begin
                tx_fifo_data_in <= sel_byte;
            end
            timeout_pulse <= timeout_hit;
        end
    end

    // Credit model: spend on each write, earn one back per modelled byte time
    always_ff @(posedge clock) begin
        if (reset) begin
            credits    <= CREDIT_FULL;
            byte_timer <= '0;
        end else begin
            if (credits == CREDIT_FULL || credit_return) begin
                byte_timer <= '0;
            end else begin
                byte_timer <= byte_timer + 1'b1;
            end
            case ({accept, credit_return})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter and
//                rr_picker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 64;
    localparam int BC    = 2342;
    localparam int ITO   = 1024;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_fifo_data_in;
    logic            tx_fifo_write_en;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_pulse;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ         (NR),
        .FIFO_DEPTH      (DEPTH),
        .CLOCK_FREQUENCY (27000000),
        .BAUD_RATE       (115200),
        .IDLE_TIMEOUT    (ITO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_data         (req_data),
        .req_valid        (req_valid),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .tx_fifo_data_in  (tx_fifo_data_in),
        .tx_fifo_write_en (tx_fifo_write_en),
        .grant_id         (grant_id),
        .busy             (busy),
        .timeout_pulse    (timeout_pulse)
    );

    logic [3:0] pk_req;
    logic [1:0] pk_ptr;
    logic [1:0] pk_win;
    logic       pk_any;

    rr_picker #(.NUM_REQ(4)) u_pick (
        .req     (pk_req),
        .ptr     (pk_ptr),
        .winner  (pk_win),
        .any_req (pk_any)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Requester model: one queue of {last, data} per source
    logic [8:0]    msgq [NR][$];
    int            stop_at [NR];
    int            acc_cnt [NR];
    logic [NR-1:0] acc_mask = '0;

    // Monitor logs
    int         cyc = 0;
    logic [7:0] wr_data [$];
    int         wr_gid [$];
    int         wr_cyc [$];
    int         to_cnt, to_cyc, max_cred, drop_acc;
    logic       to_busy, prev_rdy1;
    int         rise_cyc [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Drive requester inputs just after each rising edge
    initial begin
        logic [8:0] head;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc_mask[i] && msgq[i].size() > 0) begin
                    void'(msgq[i].pop_front());
                    acc_cnt[i]++;
                end
                head = (msgq[i].size() > 0) ? msgq[i][0] : 9'h000;
                req_valid[i] = (msgq[i].size() > 0) && (stop_at[i] < 0 || acc_cnt[i] < stop_at[i]);
                req_last[i]  = head[8];
                req_data[8*i +: 8] = head[7:0];
            end
        end
    end

    // Observe at the falling edge
    always @(negedge clock) begin
        acc_mask = req_valid & req_ready & {NR{~reset}};
        if (tx_fifo_write_en) begin
            wr_data.push_back(tx_fifo_data_in);
            wr_gid.push_back(int'(grant_id));
            wr_cyc.push_back(cyc);
        end
        if (timeout_pulse) begin
            to_cnt++;
            to_cyc  = cyc;
            to_busy = busy;
        end
        if (int'(dut.credits) > max_cred) max_cred = int'(dut.credits);
        if (req_ready[1] && !prev_rdy1) rise_cyc.push_back(cyc);
        if (busy && grant_id == 2'd1 && req_valid[1] && !req_ready[1] && drop_acc < 0)
            drop_acc = acc_cnt[1];
        prev_rdy1 = req_ready[1];
    end

    function automatic int wd(input int k);
        return (k < wr_data.size()) ? int'(wr_data[k]) : -1;
    endfunction
    function automatic int wg(input int k);
        return (k < wr_gid.size()) ? wr_gid[k] : -1;
    endfunction
    function automatic int wc(input int k);
        return (k < wr_cyc.size()) ? wr_cyc[k] : -1;
    endfunction
    function automatic int rc(input int k);
        return (k < rise_cyc.size()) ? rise_cyc[k] : -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_logs();
        wr_data.delete();
        wr_gid.delete();
        wr_cyc.delete();
        rise_cyc.delete();
        to_cnt    = 0;
        to_cyc    = -1;
        to_busy   = 1'b1;
        max_cred  = 0;
        drop_acc  = -1;
        prev_rdy1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            msgq[i].delete();
            stop_at[i] = -1;
            acc_cnt[i] = 0;
        end
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (wr_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, wr_data.size(), n);
    endtask

    initial begin
        // Picker vectors
        pk_req = 4'b0101; pk_ptr = 2'd1; #1;
        check("pick_0101_p1", pk_win, 2);
        check("pick_any", pk_any, 1);
        pk_req = 4'b0101; pk_ptr = 2'd3; #1;
        check("pick_0101_p3", pk_win, 0);
        pk_req = 4'b1000; pk_ptr = 2'd0; #1;
        check("pick_1000_p0", pk_win, 3);
        pk_req = 4'b1111; pk_ptr = 2'd2; #1;
        check("pick_1111_p2", pk_win, 2);
        pk_req = 4'b0000; pk_ptr = 2'd1; #1;
        check("pick_none", pk_any, 0);

        // Reset state
        do_reset();
        check("rst_ready", req_ready, 0);
        check("rst_wen", tx_fifo_write_en, 0);
        check("rst_data", tx_fifo_data_in, 0);
        check("rst_gid", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", timeout_pulse, 0);
        check("rst_credits", dut.credits, DEPTH);

        // Single requester, three-byte message
        msgq[0].push_back(9'h041);
        msgq[0].push_back(9'h042);
        msgq[0].push_back(9'h143);
        wait_writes("t1_count", 3, 30);
        check("t1_b0", wd(0), 8'h41);
        check("t1_b1", wd(1), 8'h42);
        check("t1_b2", wd(2), 8'h43);
        check("t1_back2back", wc(2) - wc(0), 2);
        tick();
        tick();
        check("t1_credits", dut.credits, 61);
        check("t1_busy", busy, 0);

        // Requesters 0 and 2 contend from reset
        do_reset();
        msgq[0].push_back(9'h010);
        msgq[0].push_back(9'h011);
        msgq[0].push_back(9'h112);
        msgq[2].push_back(9'h030);
        msgq[2].push_back(9'h131);
        wait_writes("t2_count", 5, 40);
        check("t2_b0", wd(0), 8'h10);
        check("t2_b2", wd(2), 8'h12);
        check("t2_b3", wd(3), 8'h30);
        check("t2_b4", wd(4), 8'h31);
        check("t2_gid_first", wg(2), 0);
        check("t2_gid_second", wg(3), 2);
        check("t2_idle_gap", wc(3) - wc(2), 2);

        // All four requesters with two single-byte messages each
        do_reset();
        for (int i = 0; i < NR; i++) begin
            msgq[i].push_back({1'b1, 8'hA0 + 8'(i)});
            msgq[i].push_back({1'b1, 8'hB0 + 8'(i)});
        end
        wait_writes("t3_count", 8, 60);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_gid%0d", k), wg(k), k % 4);
            check($sformatf("t3_data%0d", k), wd(k), (k < 4 ? 8'hA0 : 8'hB0) + (k % 4));
        end

        // Credit exhaustion with a 70-byte burst
        do_reset();
        for (int k = 0; k < 70; k++) msgq[1].push_back({(k == 69), 8'(k)});
        wait_writes("t4_count", 70, 20000);
        check("t4_last", wd(69), 69);
        check("t4_drop_after", drop_acc, 64);
        check("t4_rises", rise_cyc.size(), 7);
        check("t4_first_return", rc(1) - wc(0), BC);
        for (int k = 1; k < 6; k++)
            check($sformatf("t4_gap%0d", k), rc(k + 1) - rc(k), BC);
        check("t4_max_credits", max_cred, DEPTH);
        check("t4_no_timeout", to_cnt, 0);

        // Owner stalls mid-message; timeout hands the link to requester 3
        do_reset();
        msgq[0].push_back(9'h050);
        msgq[0].push_back(9'h051);
        msgq[0].push_back(9'h152);
        stop_at[0] = 2;
        msgq[3].push_back(9'h170);
        wait_writes("t5_count", 3, 1300);
        check("t5_tmo_count", to_cnt, 1);
        check("t5_tmo_time", to_cyc - wc(1), ITO);
        check("t5_tmo_busy", to_busy, 0);
        check("t5_next_gid", wg(2), 3);
        check("t5_next_data", wd(2), 8'h70);
        check("t5_next_time", wc(2) - to_cyc, 2);

        // Reset in the middle of a message
        do_reset();
        for (int k = 0; k < 10; k++) msgq[2].push_back({(k == 9), 8'h60 + 8'(k)});
        wait_writes("t6_count", 3, 30);
        check("t6_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        check("t6_ready", req_ready, 0);
        check("t6_wen", tx_fifo_write_en, 0);
        check("t6_data", tx_fifo_data_in, 0);
        check("t6_gid", grant_id, 0);
        check("t6_busy", busy, 0);
        check("t6_tmo", timeout_pulse, 0);
        check("t6_credits", dut.credits, DEPTH);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
